// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the load/store unit: size codes, FSM states,
// byte-enable generation and store-data lane replication.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_RESP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        RESP  = ST_RESP
    } state_e;

    // Physical byte position inside the word (0 = bits 7:0) for a byte address offset.
    function automatic logic [1:0] byte_lane(input logic [1:0] addr_lo, input logic big_endian);
        byte_lane = big_endian ? (2'd3 - addr_lo) : addr_lo;
    endfunction

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo,
                                          input logic big_endian);
        logic [1:0] lane;
        lane = byte_lane(addr_lo, big_endian);
        case (size)
            SZ_BYTE: be_gen = 4'b0001 << lane;
            SZ_HALF: be_gen = lane[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Combinational load path: picks the addressed byte/half out of the memory word and
// sign- or zero-extends it to 32 bits; words pass through.
module load_ext
    import mem_access_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [31:0] i_mem_rdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    localparam logic BE_MODE = (BIG_ENDIAN != 0);

    logic [1:0]  w_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by extension from the lane msb.
    always_comb begin
        w_lane = byte_lane(i_addr_lo, BE_MODE);
        w_byte = i_mem_rdata[{w_lane, 3'b000} +: 8];
        w_half = w_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        o_data = i_mem_rdata;
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: core valid/ready request, registered memory req/ack with timeout.
// Optional misalignment trap (rsp_misalign port) under MEM_ACCESS_UNIT_MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int BIG_ENDIAN     = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
    output logic        o_rsp_misalign,
`endif
    output logic        o_busy,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic BE_MODE = (BIG_ENDIAN != 0);

    state_e        r_state;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [1:0]    r_addr_lo;
    logic [CW-1:0] r_cnt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [3:0]    r_mem_be;
    logic [31:0]   r_mem_wdata;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_rdata;
    logic          w_misalign;
    logic          w_timeout;
    logic [31:0]   w_ext;

    load_ext #(.BIG_ENDIAN(BIG_ENDIAN)) u_load_ext (
        .i_mem_rdata (i_mem_rdata),
        .i_size      (r_size),
        .i_addr_lo   (r_addr_lo),
        .i_unsigned  (r_unsigned),
        .o_data      (w_ext)
    );

    // Final ISSUE cycle without ack; an ack in the same cycle takes priority.
    assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LAST);

    // Misalignment decode of the incoming request (reserved size behaves as word).
    always_comb begin
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
        w_misalign = 1'b0;
        case (i_req_size)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = i_req_addr[0];
            default: w_misalign = (i_req_addr[1:0] != 2'b00);
        endcase
`else
        w_misalign = 1'b0;
`endif
    end

    // Request capture, memory handshake, timeout and response generation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_size      <= i_req_size;
                        r_unsigned  <= i_req_unsigned;
                        r_addr_lo   <= i_req_addr[1:0];
                        r_cnt       <= '0;
                        r_mem_we    <= i_req_we;
                        r_mem_addr  <= {i_req_addr[31:2], 2'b00};
                        r_mem_be    <= i_req_we ? be_gen(i_req_size, i_req_addr[1:0], BE_MODE) : 4'b1111;
                        r_mem_wdata <= i_req_we ? wdata_rep(i_req_size, i_req_wdata) : 32'h0000_0000;
                        if (w_misalign) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0000_0000;
                        end else begin
                            r_state   <= ISSUE;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (i_mem_ack) begin
                        r_state     <= RESP;
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_mem_we ? 32'h0000_0000 : w_ext;
                    end else if (w_timeout) begin
                        r_state     <= RESP;
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'h0000_0000;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_req   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
    logic r_rsp_misalign;

    // Misalign flag follows the response it belongs to and holds until the next one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_misalign <= 1'b0;
        end else if ((r_state == IDLE) && i_req_valid && w_misalign) begin
            r_rsp_misalign <= 1'b1;
        end else if ((r_state == ISSUE) && (i_mem_ack || w_timeout)) begin
            r_rsp_misalign <= 1'b0;
        end else begin
            r_rsp_misalign <= r_rsp_misalign;
        end
    end

    assign o_rsp_misalign = r_rsp_misalign;
`endif

    assign o_req_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (BIG_ENDIAN=1, TIMEOUT_CYCLES=16): vector table plus
// hand-written latency, timeout, reset and misalignment sequences.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
    logic        rsp_misalign;
`endif
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.BIG_ENDIAN(1), .TIMEOUT_CYCLES(16)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
        .o_rsp_misalign (rsp_misalign),
`endif
        .o_busy         (busy),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_be       (mem_be),
        .o_mem_wdata    (mem_wdata),
        .i_mem_ack      (mem_ack),
        .i_mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid    = 1'b0;
    endtask

    // One request with ack in the first ISSUE cycle; ends back in IDLE.
    task automatic run_vec(input string tag, input vec_t v);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
        check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_we"}, {31'd0, mem_we}, {31'd0, v.we});
        check({tag, "_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
        check({tag, "_be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
        check({tag, "_wdata"}, mem_wdata, v.exp_wdata);
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        check({tag, "_rspv"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
        tick();
        check({tag, "_rspv_off"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        vec_t mv;

        //         we    size   uns   addr          wdata         rdata         be       exp_wdata     exp_rdata
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h1000_0001, 32'h0,        32'h12F4_5678, 4'b1111, 32'h0,        32'hFFFF_FFF4};
        vecs[1]  = '{1'b0, 2'b01, 1'b1, 32'h2000_0002, 32'h0,        32'h1234_ABCD, 4'b1111, 32'h0,        32'h0000_ABCD};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h3000_0003, 32'h0000_00A5, 32'h0,        4'b0001, 32'hA5A5_A5A5, 32'h0};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'h0,        32'h8011_2233, 4'b1111, 32'h0,        32'h0000_0080};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0,        32'h8011_2233, 4'b1111, 32'h0,        32'hFFFF_FF80};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0,        32'h8001_7FFF, 4'b1111, 32'h0,        32'hFFFF_8001};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,        32'h8001_7FFF, 4'b1111, 32'h0,        32'h0000_7FFF};
        vecs[7]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0304, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0402, 32'h1234_5678, 32'h0,        4'b0011, 32'h5678_5678, 32'h0};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0400, 32'hFFFF_ABCD, 32'h0,        4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h0000_0508, 32'hCAFE_F00D, 32'h0,        4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h0000_0600, 32'h1234_5677, 32'h0,        4'b1000, 32'h7777_7777, 32'h0};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h0000_0703, 32'h0,        32'h1234_56F0, 4'b1111, 32'h0,        32'h0000_00F0};
        vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h0000_080C, 32'h0,        32'h0102_0304, 4'b1111, 32'h0,        32'h0102_0304};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 32'h0000_0902, 32'h0,        32'h0000_C300, 4'b1111, 32'h0,        32'hFFFF_FFC3};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_rspv", {31'd0, rsp_valid}, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Ack delayed: request held stable cycles 1..6, response in cycle 7.
        drive_req(1'b0, 2'b10, 1'b0, 32'h4000_0010, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("dly_req_c%0d", c), {31'd0, mem_req}, 32'd1);
            check($sformatf("dly_addr_c%0d", c), mem_addr, 32'h4000_0010);
            check($sformatf("dly_busy_c%0d", c), {31'd0, req_ready, rsp_valid}, 32'd0);
            if (c == 6) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h600D_CAFE;
            end
            tick();
        end
        mem_ack = 1'b0;
        check("dly_rspv", {31'd0, rsp_valid}, 32'd1);
        check("dly_ready", {31'd0, req_ready}, 32'd0);
        check("dly_rdata", rsp_rdata, 32'h600D_CAFE);
        tick();
        check("dly_idle", {31'd0, req_ready}, 32'd1);

        // Timeout: mem_req high for 16 cycles, then an error response with zero data.
        drive_req(1'b0, 2'b10, 1'b0, 32'h4000_0020, 32'h0);
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("to_req_c%0d", c), {31'd0, mem_req}, 32'd1);
            tick();
        end
        check("to_req_drop", {31'd0, mem_req}, 32'd0);
        check("to_rspv", {31'd0, rsp_valid}, 32'd1);
        check("to_err", {31'd0, rsp_err}, 32'd1);
        check("to_rdata", rsp_rdata, 32'd0);
        tick();
        check("to_rspv_off", {31'd0, rsp_valid}, 32'd0);
        check("to_ready", {31'd0, req_ready}, 32'd1);

        // Ack in the final ISSUE cycle beats the timeout.
        drive_req(1'b0, 2'b10, 1'b0, 32'h4000_0030, 32'h0);
        for (int c = 1; c <= 15; c++) tick();
        check("tie_req", {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        check("tie_rspv", {31'd0, rsp_valid}, 32'd1);
        check("tie_err", {31'd0, rsp_err}, 32'd0);
        check("tie_rdata", rsp_rdata, 32'h0BAD_F00D);
        tick();

        // Reset in the middle of ISSUE aborts without a response.
        drive_req(1'b0, 2'b10, 1'b0, 32'h4000_0040, 32'h0);
        tick();
        check("mid_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_ready", {31'd0, req_ready}, 32'd1);
        check("mid_req_off", {31'd0, mem_req}, 32'd0);
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) n++;
            tick();
        end
        check("mid_no_rsp", n, 32'd0);

        // Back-to-back with ack always high: one response per 3 cycles.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0010;
        mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
        tick();
        n = 0;
        for (int c = 1; c <= 9; c++) begin
            if (rsp_valid) n++;
            tick();
        end
        req_valid = 1'b0;
        check("b2b_count", n, 32'd3);
        tick();
        tick();
        mem_ack = 1'b0;
        check("b2b_idle", {31'd0, req_ready}, 32'd1);

`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
        // Misaligned word load traps straight to a response, no memory request.
        drive_req(1'b0, 2'b10, 1'b0, 32'h5000_0002, 32'h0);
        check("mis_req", {31'd0, mem_req}, 32'd0);
        check("mis_rspv", {31'd0, rsp_valid}, 32'd1);
        check("mis_err", {31'd0, rsp_err}, 32'd1);
        check("mis_flag", {31'd0, rsp_misalign}, 32'd1);
        check("mis_rdata", rsp_rdata, 32'd0);
        tick();
        check("mis_ready", {31'd0, req_ready}, 32'd1);
        check("mis_req_off", {31'd0, mem_req}, 32'd0);
        run_vec("mis_after", vecs[0]);
        check("mis_clear", {31'd0, rsp_misalign}, 32'd0);
`else
        // Without the trap, misaligned half/word requests are silently aligned.
        mv = '{1'b0, 2'b10, 1'b0, 32'h5000_0002, 32'h0, 32'h1122_3344, 4'b1111, 32'h0, 32'h1122_3344};
        run_vec("al_word", mv);
        mv = '{1'b0, 2'b01, 1'b0, 32'h5000_0003, 32'h0, 32'hAABB_8899, 4'b1111, 32'h0, 32'hFFFF_8899};
        run_vec("al_half", mv);
        mv = '{1'b1, 2'b01, 1'b0, 32'h5000_0001, 32'h0000_BEEF, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        run_vec("al_sh", mv);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
